// File: rtl/spi_bus_bridge.sv
// SPI-slave to register-bus bridge, fully oversampled in the clk25 domain.
// A frame is: CMD byte (bit7 = write, bit6 = auto-increment), an address field
// of 8*ceil(ADDR_W/8) bits, then any number of DATA_W-bit words. SPI mode 0,
// MSB first.
//
// Ports:
//   clk25, rst_n            system clock, asynchronous active-low reset
//   spi_sck_i/cs_n_i/mosi_i asynchronous SPI pins (synchronised here)
//   spi_miso_o, spi_miso_oe MISO data and pad enable (enabled only while reading)
//   sys_addr_o, sys_wdata_o register-bus address and write data
//   sys_wr_o, sys_rd_o      one-cycle write / read strobes
//   sys_rdata_i             read data, valid RD_LAT cycles after sys_rd_o
//   busy_o                  synchronised chip-select asserted
//   frame_err_o             one-cycle pulse when CS rises mid-word
module spi_bus_bridge #(
  parameter int ADDR_W = 5,
  parameter int DATA_W = 8,
  parameter int RD_LAT = 1
) (
  input  logic              clk25,
  input  logic              rst_n,
  input  logic              spi_sck_i,
  input  logic              spi_cs_n_i,
  input  logic              spi_mosi_i,
  output logic              spi_miso_o,
  output logic              spi_miso_oe,
  output logic [ADDR_W-1:0] sys_addr_o,
  output logic [DATA_W-1:0] sys_wdata_o,
  output logic              sys_wr_o,
  output logic              sys_rd_o,
  input  logic [DATA_W-1:0] sys_rdata_i,
  output logic              busy_o,
  output logic              frame_err_o
);
  localparam int AF_W  = 8 * ((ADDR_W + 7) / 8);
  localparam int SR_W  = (AF_W > DATA_W) ? AF_W : DATA_W;
  localparam int CNT_W = $clog2(SR_W);

  typedef enum logic [2:0] {IDLE, CMD, ADDR, WDATA, RDATA} state_t;

  state_t state, state_next;

  logic sck_p0, sck_p1, sck_p2;
  logic cs_p0, cs_p1, cs_p2;
  logic mosi_p0, mosi_p1, mosi_p2;
  logic sck_rise, sck_fall, cs_fall, cs_rise;

  logic [CNT_W-1:0]  bit_cnt, last_idx;
  logic [SR_W-2:0]   in_sr;
  logic [SR_W-1:0]   shifted;
  logic              is_write, auto_inc;
  logic              last_bit, cmd_done, addr_done, wr_word, rd_word, abort;
  logic [2:0]        rd_q;
  logic [3:0]        rd_tap;
  logic              rd_ld;
  logic [DATA_W-1:0] miso_sr;
  logic              miso_q;

  // Stage p0/p1: two-flop synchronisers; stage p2: edge-detect register
  always_ff @(posedge clk25 or negedge rst_n) begin
    if (!rst_n) begin
      sck_p0  <= 1'b0;
      sck_p1  <= 1'b0;
      sck_p2  <= 1'b0;
      cs_p0   <= 1'b1;
      cs_p1   <= 1'b1;
      cs_p2   <= 1'b1;
      mosi_p0 <= 1'b0;
      mosi_p1 <= 1'b0;
      mosi_p2 <= 1'b0;
    end else begin
      sck_p0  <= spi_sck_i;
      sck_p1  <= sck_p0;
      sck_p2  <= sck_p1;
      cs_p0   <= spi_cs_n_i;
      cs_p1   <= cs_p0;
      cs_p2   <= cs_p1;
      mosi_p0 <= spi_mosi_i;
      mosi_p1 <= mosi_p0;
      mosi_p2 <= mosi_p1;
    end
  end

  assign sck_rise = sck_p1 & ~sck_p2;
  assign sck_fall = ~sck_p1 & sck_p2;
  assign cs_fall  = ~cs_p1 & cs_p2;
  assign cs_rise  = cs_p1 & ~cs_p2;
  assign busy_o   = ~cs_p1;

  // Most recent bits of the current field, LSB = bit arriving this cycle
  assign shifted = {in_sr, mosi_p2};

  always_ff @(posedge clk25 or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    last_idx   = '0;
    case (state)
      CMD:          last_idx = CNT_W'(7);
      ADDR:         last_idx = CNT_W'(AF_W - 1);
      WDATA, RDATA: last_idx = CNT_W'(DATA_W - 1);
      default:      last_idx = '0;
    endcase
    last_bit  = sck_rise && (state != IDLE) && (bit_cnt == last_idx);
    cmd_done  = 1'b0;
    addr_done = 1'b0;
    wr_word   = 1'b0;
    rd_word   = 1'b0;
    abort     = 1'b0;
    case (state)
      IDLE:  if (cs_fall) state_next = CMD;
      CMD:   if (last_bit) begin
               cmd_done   = 1'b1;
               state_next = ADDR;
             end
      ADDR:  if (last_bit) begin
               addr_done  = 1'b1;
               state_next = is_write ? WDATA : RDATA;
             end
      WDATA: wr_word = last_bit;
      RDATA: rd_word = last_bit;
      default: state_next = IDLE;
    endcase
    // A last bit arriving together with CS rise still counts as a complete word
    if ((state != IDLE) && cs_rise) begin
      state_next = IDLE;
      abort      = (bit_cnt != '0) && !last_bit;
    end
  end

  // Read-latency tap: tap 0 is the strobe itself, taps 1..3 are delayed copies
  assign rd_tap = {rd_q, sys_rd_o};
  assign rd_ld  = |(rd_tap & (4'b0001 << RD_LAT));

  always_ff @(posedge clk25 or negedge rst_n) begin
    if (!rst_n) begin
      bit_cnt     <= '0;
      in_sr       <= '0;
      is_write    <= 1'b0;
      auto_inc    <= 1'b0;
      sys_addr_o  <= '0;
      sys_wdata_o <= '0;
      sys_wr_o    <= 1'b0;
      sys_rd_o    <= 1'b0;
      frame_err_o <= 1'b0;
      rd_q        <= '0;
      miso_sr     <= '0;
      miso_q      <= 1'b0;
    end else begin
      if (state == IDLE) begin
        bit_cnt <= '0;
      end else if (sck_rise) begin
        in_sr   <= shifted[SR_W-2:0];
        bit_cnt <= last_bit ? '0 : bit_cnt + CNT_W'(1);
      end
      if (cmd_done) begin
        is_write <= shifted[7];
        auto_inc <= shifted[6];
      end
      // Reads advance before the lookahead strobe; writes advance after theirs
      if (addr_done)
        sys_addr_o <= shifted[ADDR_W-1:0];
      else if ((rd_word || sys_wr_o) && auto_inc)
        sys_addr_o <= sys_addr_o + ADDR_W'(1);
      if (wr_word)
        sys_wdata_o <= shifted[DATA_W-1:0];
      sys_wr_o    <= wr_word;
      sys_rd_o    <= (addr_done && !is_write) || rd_word;
      frame_err_o <= abort;
      rd_q        <= {rd_q[1:0], sys_rd_o};
      if (rd_ld)
        miso_sr <= sys_rdata_i;
      else if ((state == RDATA) && sck_fall)
        miso_sr <= {miso_sr[DATA_W-2:0], 1'b0};
      if (state != RDATA)
        miso_q <= 1'b0;
      else if (sck_fall)
        miso_q <= miso_sr[DATA_W-1];
    end
  end

  assign spi_miso_oe = (state == RDATA) && !cs_p1;
  assign spi_miso_o  = miso_q && spi_miso_oe;

endmodule

// File: tb/tb_spi_bus_bridge.sv
// Directed bench for spi_bus_bridge: three instances (RD_LAT 0, 2, 3) share the
// SPI pins; each has its own bus model. Frames come from a vector table, plus
// hand-written abort, simultaneous-edge and reset-mid-frame sequences.
module tb_spi_bus_bridge;
  localparam int HALF = 10;   // clk25 cycles per SCK half period
  localparam int NV   = 10;

  logic clk25 = 1'b0;
  logic rst_n = 1'b0;
  logic sck = 1'b0, cs_n = 1'b1, mosi = 1'b0;
  always #5 clk25 = ~clk25;

  logic       miso0, oe0, wr0, rd0, busy0, err0;
  logic       miso2, oe2, wr2, rd2, busy2, err2;
  logic       miso3, oe3, wr3, rd3, busy3, err3;
  logic [4:0] addr0, addr2, addr3;
  logic [7:0] wdata0, wdata2, wdata3, rdata0, rdata2, rdata3;

  spi_bus_bridge #(.ADDR_W(5), .DATA_W(8), .RD_LAT(0)) u0 (
    .clk25(clk25), .rst_n(rst_n), .spi_sck_i(sck), .spi_cs_n_i(cs_n), .spi_mosi_i(mosi),
    .spi_miso_o(miso0), .spi_miso_oe(oe0), .sys_addr_o(addr0), .sys_wdata_o(wdata0),
    .sys_wr_o(wr0), .sys_rd_o(rd0), .sys_rdata_i(rdata0), .busy_o(busy0), .frame_err_o(err0));
  spi_bus_bridge #(.ADDR_W(5), .DATA_W(8), .RD_LAT(2)) u2 (
    .clk25(clk25), .rst_n(rst_n), .spi_sck_i(sck), .spi_cs_n_i(cs_n), .spi_mosi_i(mosi),
    .spi_miso_o(miso2), .spi_miso_oe(oe2), .sys_addr_o(addr2), .sys_wdata_o(wdata2),
    .sys_wr_o(wr2), .sys_rd_o(rd2), .sys_rdata_i(rdata2), .busy_o(busy2), .frame_err_o(err2));
  spi_bus_bridge #(.ADDR_W(5), .DATA_W(8), .RD_LAT(3)) u3 (
    .clk25(clk25), .rst_n(rst_n), .spi_sck_i(sck), .spi_cs_n_i(cs_n), .spi_mosi_i(mosi),
    .spi_miso_o(miso3), .spi_miso_oe(oe3), .sys_addr_o(addr3), .sys_wdata_o(wdata3),
    .sys_wr_o(wr3), .sys_rd_o(rd3), .sys_rdata_i(rdata3), .busy_o(busy3), .frame_err_o(err3));

  // Register-bus read model: data is presented only in the cycle it is due
  function automatic logic [7:0] mem_of(input logic [4:0] a);
    case (a)
      5'h03:   mem_of = 8'hA5;
      5'h10:   mem_of = 8'h3C;
      5'h11:   mem_of = 8'hC3;
      5'h1F:   mem_of = 8'h96;
      default: mem_of = {a[2:0], a};
    endcase
  endfunction

  logic [2:0] v2_q, v3_q;
  logic [4:0] a2_q [3];
  logic [4:0] a3_q [3];
  always @(posedge clk25) begin
    if (!rst_n) begin
      v2_q <= '0;
      v3_q <= '0;
    end else begin
      v2_q <= {v2_q[1:0], rd2};
      v3_q <= {v3_q[1:0], rd3};
    end
    a2_q[0] <= addr2; a2_q[1] <= a2_q[0]; a2_q[2] <= a2_q[1];
    a3_q[0] <= addr3; a3_q[1] <= a3_q[0]; a3_q[2] <= a3_q[1];
  end
  assign rdata0 = rd0     ? mem_of(addr0)   : 8'h00;
  assign rdata2 = v2_q[1] ? mem_of(a2_q[1]) : 8'h00;
  assign rdata3 = v3_q[2] ? mem_of(a3_q[2]) : 8'h00;

  // Strobe monitors
  logic [4:0] wr_a [8];
  logic [7:0] wr_d [8];
  logic [4:0] rd_a [3][8];
  int wr_n, err_n, both_n, pin_bad;
  int rd_n [3];
  initial both_n = 0;
  always @(negedge clk25) begin
    if (wr2) begin
      if (wr_n < 8) begin wr_a[wr_n] = addr2; wr_d[wr_n] = wdata2; end
      wr_n++;
    end
    if (rd0) begin if (rd_n[0] < 8) rd_a[0][rd_n[0]] = addr0; rd_n[0]++; end
    if (rd2) begin if (rd_n[1] < 8) rd_a[1][rd_n[1]] = addr2; rd_n[1]++; end
    if (rd3) begin if (rd_n[2] < 8) rd_a[2][rd_n[2]] = addr3; rd_n[2]++; end
    if (err2) err_n++;
    if ((wr0 & rd0) | (wr2 & rd2) | (wr3 & rd3)) both_n++;
  end

  int checks = 0, errors = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  task automatic clear_mon();
    wr_n = 0; err_n = 0; pin_bad = 0;
    for (int d = 0; d < 3; d++) rd_n[d] = 0;
  endtask

  // Shift nbits of b out MSB first; MISO is captured just before each rise
  task automatic xfer(input logic [7:0] b, input int nbits, input logic exp_oe,
                      output logic [7:0] m0, output logic [7:0] m2, output logic [7:0] m3);
    m0 = '0; m2 = '0; m3 = '0;
    for (int i = 0; i < nbits; i++) begin
      mosi = b[7-i];
      repeat (HALF) @(negedge clk25);
      m0 = {m0[6:0], miso0};
      m2 = {m2[6:0], miso2};
      m3 = {m3[6:0], miso3};
      if ({oe0, oe2, oe3} !== {3{exp_oe}}) pin_bad++;
      if (!exp_oe && (miso0 | miso2 | miso3)) pin_bad++;
      if ({busy0, busy2, busy3} !== 3'b111) pin_bad++;
      sck = 1'b1;
      repeat (HALF) @(negedge clk25);
      sck = 1'b0;
    end
  endtask

  task automatic run_frame(input logic [7:0] cmd, input logic [7:0] addr, input int nw,
                           input logic [23:0] data,
                           output logic [23:0] r0, output logic [23:0] r2, output logic [23:0] r3);
    logic [7:0] m0, m2, m3;
    r0 = '0; r2 = '0; r3 = '0;
    cs_n = 1'b0;
    repeat (4) @(negedge clk25);
    xfer(cmd, 8, 1'b0, m0, m2, m3);
    if (nw >= 0) xfer(addr, 8, 1'b0, m0, m2, m3);
    for (int w = 0; w < nw; w++) begin
      xfer(data[23-8*w -: 8], 8, !cmd[7], m0, m2, m3);
      r0[23-8*w -: 8] = m0;
      r2[23-8*w -: 8] = m2;
      r3[23-8*w -: 8] = m3;
    end
    repeat (HALF) @(negedge clk25);
    cs_n = 1'b1;
    repeat (8) @(negedge clk25);
  endtask

  typedef struct {
    logic [7:0]  cmd;
    logic [7:0]  addr;
    int          nw;      // -1: frame ends after CMD
    logic [23:0] data;
    int          exp_wr;
    logic [14:0] ea;      // expected write addresses, word 0 in the top field
    logic [23:0] ed;      // expected write data
    int          exp_rd;
    logic [14:0] er;      // expected read-strobe addresses
    logic [23:0] em;      // expected MISO words
  } vec_t;

  vec_t vecs [NV];

  initial begin
    #800000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [23:0] r0, r2, r3;
    logic [7:0]  m0, m2, m3;

    vecs[0] = '{8'h80, 8'h0A, 1, 24'h5A0000, 1, {5'h0A, 5'h00, 5'h00}, 24'h5A0000, 0, 15'h0, 24'h0};
    vecs[1] = '{8'hC0, 8'h1E, 3, 24'h112233, 3, {5'h1E, 5'h1F, 5'h00}, 24'h112233, 0, 15'h0, 24'h0};
    vecs[2] = '{8'h80, 8'h05, 2, 24'hAABB00, 2, {5'h05, 5'h05, 5'h00}, 24'hAABB00, 0, 15'h0, 24'h0};
    vecs[3] = '{8'h80, 8'hE7, 1, 24'h420000, 1, {5'h07, 5'h00, 5'h00}, 24'h420000, 0, 15'h0, 24'h0};
    vecs[4] = '{8'h80, 8'h00, -1, 24'h0, 0, 15'h0, 24'h0, 0, 15'h0, 24'h0};
    vecs[5] = '{8'h80, 8'h08, 0, 24'h0, 0, 15'h0, 24'h0, 0, 15'h0, 24'h0};
    vecs[6] = '{8'h00, 8'h03, 1, 24'h0, 0, 15'h0, 24'h0, 2, {5'h03, 5'h03, 5'h00}, 24'hA50000};
    vecs[7] = '{8'h40, 8'h10, 2, 24'h0, 0, 15'h0, 24'h0, 3, {5'h10, 5'h11, 5'h12}, 24'h3CC300};
    vecs[8] = '{8'h00, 8'h07, 0, 24'h0, 0, 15'h0, 24'h0, 1, {5'h07, 5'h00, 5'h00}, 24'h0};
    vecs[9] = '{8'h7F, 8'h1F, 1, 24'h0, 0, 15'h0, 24'h0, 2, {5'h1F, 5'h00, 5'h00}, 24'h960000};

    clear_mon();
    rst_n = 1'b0;
    repeat (5) @(negedge clk25);
    rst_n = 1'b1;
    repeat (5) @(negedge clk25);
    chk("reset_state",
        {miso0, oe0, addr0, wdata0, wr0, rd0, busy0, err0,
         miso2, oe2, addr2, wdata2, wr2, rd2, busy2, err2,
         miso3, oe3, addr3, wdata3, wr3, rd3, busy3, err3}, 32'h0);

    for (int v = 0; v < NV; v++) begin
      clear_mon();
      run_frame(vecs[v].cmd, vecs[v].addr, vecs[v].nw, vecs[v].data, r0, r2, r3);
      chk($sformatf("v%0d_wr_count", v), wr_n, vecs[v].exp_wr);
      for (int i = 0; i < vecs[v].exp_wr && i < 3; i++) begin
        chk($sformatf("v%0d_wr%0d_addr", v, i), wr_a[i], vecs[v].ea[14-5*i -: 5]);
        chk($sformatf("v%0d_wr%0d_data", v, i), wr_d[i], vecs[v].ed[23-8*i -: 8]);
      end
      for (int d = 0; d < 3; d++) begin
        chk($sformatf("v%0d_dut%0d_rd_count", v, d), rd_n[d], vecs[v].exp_rd);
        for (int k = 0; k < vecs[v].exp_rd && k < 3; k++)
          chk($sformatf("v%0d_dut%0d_rd%0d_addr", v, d, k), rd_a[d][k], vecs[v].er[14-5*k -: 5]);
      end
      if (!vecs[v].cmd[7]) begin
        for (int w = 0; w < vecs[v].nw; w++) begin
          chk($sformatf("v%0d_w%0d_miso_lat0", v, w), r0[23-8*w -: 8], vecs[v].em[23-8*w -: 8]);
          chk($sformatf("v%0d_w%0d_miso_lat2", v, w), r2[23-8*w -: 8], vecs[v].em[23-8*w -: 8]);
          chk($sformatf("v%0d_w%0d_miso_lat3", v, w), r3[23-8*w -: 8], vecs[v].em[23-8*w -: 8]);
        end
      end
      chk($sformatf("v%0d_frame_err", v), err_n, 0);
      chk($sformatf("v%0d_pins_in_frame", v), pin_bad, 0);
      chk($sformatf("v%0d_idle_pins", v), {busy0, busy2, busy3, oe0, oe2, oe3}, 0);
    end

    // Abort: CS rises after 5 data bits of a write
    clear_mon();
    cs_n = 1'b0;
    repeat (4) @(negedge clk25);
    xfer(8'h80, 8, 1'b0, m0, m2, m3);
    xfer(8'h04, 8, 1'b0, m0, m2, m3);
    xfer(8'hF0, 5, 1'b0, m0, m2, m3);
    repeat (HALF) @(negedge clk25);
    cs_n = 1'b1;
    repeat (8) @(negedge clk25);
    chk("abort_no_write", wr_n, 0);
    chk("abort_err_pulses", err_n, 1);
    chk("abort_busy_low", busy2, 0);
    clear_mon();
    run_frame(8'h80, 8'h04, 1, 24'h3C0000, r0, r2, r3);
    chk("after_abort_wr_count", wr_n, 1);
    chk("after_abort_wr", {wr_a[0], wr_d[0]}, {5'h04, 8'h3C});
    chk("after_abort_err", err_n, 0);

    // CS rise in the same cycle as the last data bit's SCK rise
    clear_mon();
    cs_n = 1'b0;
    repeat (4) @(negedge clk25);
    xfer(8'h80, 8, 1'b0, m0, m2, m3);
    xfer(8'h09, 8, 1'b0, m0, m2, m3);
    xfer(8'hC6, 7, 1'b0, m0, m2, m3);
    mosi = 1'b0;
    repeat (HALF) @(negedge clk25);
    sck  = 1'b1;
    cs_n = 1'b1;
    repeat (HALF) @(negedge clk25);
    sck = 1'b0;
    repeat (8) @(negedge clk25);
    chk("simul_wr_count", wr_n, 1);
    chk("simul_wr", {wr_a[0], wr_d[0]}, {5'h09, 8'hC6});
    chk("simul_err", err_n, 0);

    // Reset during the address field
    clear_mon();
    cs_n = 1'b0;
    repeat (4) @(negedge clk25);
    xfer(8'h80, 8, 1'b0, m0, m2, m3);
    xfer(8'h15, 4, 1'b0, m0, m2, m3);
    rst_n = 1'b0;
    #1;
    chk("reset_midframe_outputs",
        {miso2, oe2, addr2, wdata2, wr2, rd2, busy2, err2}, 32'h0);
    repeat (3) @(negedge clk25);
    cs_n = 1'b1;
    sck  = 1'b0;
    repeat (3) @(negedge clk25);
    rst_n = 1'b1;
    repeat (5) @(negedge clk25);
    chk("reset_midframe_no_strobe", wr_n + err_n + rd_n[1], 0);
    clear_mon();
    run_frame(8'h80, 8'h07, 1, 24'hFF0000, r0, r2, r3);
    chk("after_reset_wr_count", wr_n, 1);
    chk("after_reset_wr", {wr_a[0], wr_d[0]}, {5'h07, 8'hFF});

    chk("wr_rd_overlap", both_n, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
